// File: rtl/divider_pkg.sv
// Shared types and sizing helpers for the sequential restoring divider.
package divider_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } state_t;

   // Iteration counter width: must hold values 0..N-1 with headroom.
   function automatic int cnt_width(input int n);
      return $clog2(n) + 1;
   endfunction

endpackage

// File: rtl/seq_divider_cla.sv
// Parallel-prefix carry-lookahead adder/subtractor; ADD_SUB=1 computes A-B with COUT as no-borrow.
module CLA #(
   parameter int W = 33
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   input  logic         add_sub_i,
   output logic [W-1:0] sum_o,
   output logic         cout_o
);

   localparam int LV = $clog2(W);

   logic [W-1:0] bx;
   logic [W-1:0] p0;
   logic [W-1:0] g0;
   logic [W-1:0] g;
   logic [W-1:0] p;
   logic [W-1:0] gn;
   logic [W-1:0] pn;

   always_comb begin
      bx = b_i ^ {W{add_sub_i}};
      p0 = a_i ^ bx;
      g0 = a_i & bx;
      g  = g0;
      p  = p0;
      // Carry-in folded into bit 0 so every prefix g[i] is the carry out of bit i.
      g[0] = g0[0] | (p0[0] & add_sub_i);
      gn = g;
      pn = p;
      for (int k = 0; k < LV; k++) begin
         gn = g;
         pn = p;
         for (int i = (1 << k); i < W; i++) begin
            gn[i] = g[i] | (p[i] & g[i - (1 << k)]);
            pn[i] = p[i] & p[i - (1 << k)];
         end
         g = gn;
         p = pn;
      end
      sum_o  = p0 ^ {g[W-2:0], add_sub_i};
      cout_o = g[W-1];
   end

endmodule

// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit per clock, START/DONE handshake.
module seq_divider
   import divider_pkg::*;
#(
   parameter int N = 32
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         START,
   input  logic [N-1:0] DIVIDEND,
   input  logic [N-1:0] DIVISOR,
   output logic         BUSY,
   output logic         DONE,
   output logic [N-1:0] QUOTIENT,
   output logic [N-1:0] REMAINDER,
   output logic         DIV_ZERO,
   output logic [1:0]   DBG_STATE
);

   // Handshake: START is sampled only in IDLE/FIN (BUSY=0); DONE pulses one
   // cycle with results, which then hold until the next accepted START.

   localparam int CW = cnt_width(N);

   state_t         state_q;
   logic [CW-1:0]  cnt_q;
   logic [N-1:0]   rem_q;
   logic [N-1:0]   q_q;
   logic [N-1:0]   dvsr_q;
   logic [N-1:0]   quo_q;
   logic [N-1:0]   remo_q;
   logic           busy_q;
   logic           done_q;
   logic           dz_q;

   logic [N:0]     shifted;
   logic [N:0]     trial;
   logic           no_borrow;
   logic [N-1:0]   rem_d;
   logic [N-1:0]   q_d;
   logic           unused_trial_msb;

   assign shifted = {rem_q, q_q[N-1]};

   CLA #(
      .W (N + 1)
   ) u_cla (
      .a_i       (shifted),
      .b_i       ({1'b0, dvsr_q}),
      .add_sub_i (1'b1),
      .sum_o     (trial),
      .cout_o    (no_borrow)
   );

   // With no borrow the trial result is below the divisor, so its MSB is always zero.
   assign unused_trial_msb = trial[N];

   always_comb begin
      rem_d = no_borrow ? trial[N-1:0] : shifted[N-1:0];
      q_d   = {q_q[N-2:0], no_borrow};
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rem_q   <= '0;
         q_q     <= '0;
         dvsr_q  <= '0;
         quo_q   <= '0;
         remo_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         dz_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            RUN: begin
               rem_q <= rem_d;
               q_q   <= q_d;
               cnt_q <= cnt_q + CW'(1);
               if (cnt_q == CW'(N - 1)) begin
                  state_q <= FIN;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  quo_q   <= q_d;
                  remo_q  <= rem_d;
               end
            end
            default: begin
               if (START) begin
                  dvsr_q <= DIVISOR;
                  rem_q  <= '0;
                  cnt_q  <= '0;
                  q_q    <= DIVIDEND;
                  dz_q   <= 1'b0;
                  if (DIVISOR == '0) begin
                     state_q <= FIN;
                     done_q  <= 1'b1;
                     quo_q   <= '1;
                     remo_q  <= DIVIDEND;
                     dz_q    <= 1'b1;
                  end else begin
                     state_q <= RUN;
                     busy_q  <= 1'b1;
                  end
               end else begin
                  state_q <= IDLE;
               end
            end
         endcase
      end
   end

   assign BUSY      = busy_q;
   assign DONE      = done_q;
   assign QUOTIENT  = quo_q;
   assign REMAINDER = remo_q;
   assign DIV_ZERO  = dz_q;
   assign DBG_STATE = state_q;

endmodule
